// File: rtl/even_pipe.sv
// Even execution pipe of the SPU-lite core: single-cycle decode/compute of one
// even-pipe op, then a 7-stage packet shift line for forwarding and write-back.

package descriptions;
    typedef enum logic [6:0] {
        NOP,
        ADD_HALFWORD, ADD_HALFWORD_IMMEDIATE, ADD_WORD, ADD_WORD_IMMEDIATE,
        SUBTRACT_FROM_HALFWORD, SUBTRACT_FROM_HALFWORD_IMMEDIATE,
        SUBTRACT_FROM_WORD, SUBTRACT_FROM_WORD_IMMEDIATE,
        CARRY_GENERATE, BORROW_GENERATE,
        AND, AND_WITH_COMPLEMENT, OR, OR_WITH_COMPLEMENT, XOR, NAND, NOR,
        AND_HALFWORD_IMMEDIATE, AND_WORD_IMMEDIATE, OR_HALFWORD_IMMEDIATE,
        OR_WORD_IMMEDIATE, XOR_HALFWORD_IMMEDIATE, XOR_WORD_IMMEDIATE,
        COMPARE_EQUAL_HALFWORD, COMPARE_EQUAL_WORD,
        COMPARE_GREATER_THAN_HALFWORD, COMPARE_GREATER_THAN_WORD,
        COMPARE_LOGICAL_GREATER_THAN_HALFWORD, COMPARE_LOGICAL_GREATER_THAN_WORD,
        IMMEDIATE_LOAD_HALFWORD, IMMEDIATE_LOAD_HALFWORD_UPPER,
        IMMEDIATE_LOAD_WORD, IMMEDIATE_LOAD_ADDRESS,
        FORM_SELECT_MASK_HALFWORD, FORM_SELECT_MASK_WORD, COUNT_LEADING_ZEROS,
        SHIFT_LEFT_HALFWORD, SHIFT_LEFT_HALFWORD_IMMEDIATE,
        SHIFT_LEFT_WORD, SHIFT_LEFT_WORD_IMMEDIATE,
        ROTATE_HALFWORD, ROTATE_HALFWORD_IMMEDIATE, ROTATE_WORD, ROTATE_WORD_IMMEDIATE,
        ABSOLUTE_DIFFERENCE_OF_BYTES, AVERAGE_BYTES, SUM_BYTES_INTO_HALFWORDS,
        COUNT_ONES_IN_BYTES,
        FLOATING_MULTIPLY, FLOATING_MULTIPLY_AND_ADD, FLOATING_MULTIPLY_AND_SUBTRACT,
        FLOATING_NEGATIVE_MULTIPLY_AND_SUBTRACT,
        MULTIPLY, MULTIPLY_UNSIGNED, MULTIPLY_IMMEDIATE, MULTIPLY_UNSIGNED_IMMEDIATE,
        MULTIPLY_AND_ADD, MULTIPLY_HIGH
    } opcode;

    typedef struct packed {
        logic [127:0] result;
        logic [6:0]   rt_address;
        logic         wr_en;
        logic [2:0]   unit_id;
        logic [3:0]   latency;
    } ep_packet_t;
endpackage

module even_pipe
    import descriptions::*;
(
    input  logic         clock,
    input  logic         reset,
    input  opcode        ep_input_op_code,
    input  logic [127:0] ra_input,
    input  logic [127:0] rb_input,
    input  logic [127:0] rc_input,
    input  logic [6:0]   rt_address_input,
    input  logic [6:0]   I7_input,
    input  logic [9:0]   I10_input,
    input  logic [15:0]  I16_input,
    input  logic [17:0]  I18_input,
    output logic [142:0] fw_ep_st_1,
    output logic [142:0] fw_ep_st_2,
    output logic [142:0] fw_ep_st_3,
    output logic [142:0] fw_ep_st_4,
    output logic [142:0] fw_ep_st_5,
    output logic [142:0] fw_ep_st_6,
    output logic [142:0] fw_ep_st_7,
    output logic [142:0] out_ep
);
    localparam int unsigned STAGES = 7;

    logic [31:0]  i10_w;
    logic [15:0]  i10_h;
    logic         unused_i7;
    logic [127:0] res_q, res_h, res_w, res_b;
    logic [2:0]   unit;
    logic [3:0]   lat;
    ep_packet_t   issue_pkt;
    ep_packet_t   stage [1:STAGES];

    assign i10_w     = {{22{I10_input[9]}}, I10_input};
    assign i10_h     = i10_w[15:0];
    assign unused_i7 = I7_input[6];

    function automatic logic [15:0] shl16(input logic [15:0] v, input logic [4:0] n);
        return (n > 5'd15) ? 16'd0 : v << n[3:0];
    endfunction

    function automatic logic [31:0] shl32(input logic [31:0] v, input logic [5:0] n);
        return (n > 6'd31) ? 32'd0 : v << n[4:0];
    endfunction

    function automatic logic [15:0] rotl16(input logic [15:0] v, input logic [3:0] n);
        return 16'(({v, v} << n) >> 16);
    endfunction

    function automatic logic [31:0] rotl32(input logic [31:0] v, input logic [4:0] n);
        return 32'(({v, v} << n) >> 32);
    endfunction

    function automatic logic [31:0] clz32(input logic [31:0] v);
        logic [31:0] n;
        n = 32'd32;
        for (int b = 0; b < 32; b++)
            if (v[b]) n = 32'(31 - b);
        return n;
    endfunction

    function automatic logic [15:0] byte_sum(input logic [31:0] v);
        return 16'(v[31:24]) + 16'(v[23:16]) + 16'(v[15:8]) + 16'(v[7:0]);
    endfunction

    // Behavioural float model: singles widen exactly to double; denormals flush to zero
    function automatic real sp_to_real(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:23] == 8'd0)       d = {f[31], 63'd0};
        else if (f[30:23] == 8'hFF) d = {f[31], 11'h7FF, f[22:0], 29'd0};
        else                        d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    // Double to single, round-to-nearest-even on the dropped 29 mantissa bits
    function automatic logic [31:0] real_to_sp(input real r);
        logic [63:0] d;
        logic [31:0] m;
        logic        rnd;
        int          e;
        d = $realtobits(r);
        if (d[62:52] == 11'h7FF)
            return (d[51:0] != 52'd0) ? 32'h7FC0_0000 : {d[63], 8'hFF, 23'd0};
        e = int'(d[62:52]) - 896;
        if (e <= 0)   return {d[63], 31'd0};
        if (e >= 255) return {d[63], 8'hFF, 23'd0};
        rnd = d[28] && (d[29] || (d[27:0] != 28'd0));
        m   = {1'b0, 8'(e), d[51:29]} + 32'(rnd);
        return {d[63], m[30:0]};
    endfunction

    // Execution unit and latency by opcode range
    always_comb begin
        unit = 3'd0;
        lat  = 4'd0;
        if (ep_input_op_code >= ADD_HALFWORD && ep_input_op_code <= COUNT_LEADING_ZEROS) begin
            unit = 3'd1; lat = 4'd2;
        end else if (ep_input_op_code >= SHIFT_LEFT_HALFWORD && ep_input_op_code <= ROTATE_WORD_IMMEDIATE) begin
            unit = 3'd2; lat = 4'd4;
        end else if (ep_input_op_code >= ABSOLUTE_DIFFERENCE_OF_BYTES && ep_input_op_code <= COUNT_ONES_IN_BYTES) begin
            unit = 3'd3; lat = 4'd4;
        end else if (ep_input_op_code >= FLOATING_MULTIPLY && ep_input_op_code <= FLOATING_NEGATIVE_MULTIPLY_AND_SUBTRACT) begin
            unit = 3'd4; lat = 4'd6;
        end else if (ep_input_op_code >= MULTIPLY && ep_input_op_code <= MULTIPLY_HIGH) begin
            unit = 3'd5; lat = 4'd7;
        end
    end

    always_comb begin
        case (ep_input_op_code)
            AND:                 res_q = ra_input & rb_input;
            AND_WITH_COMPLEMENT: res_q = ra_input & ~rb_input;
            OR:                  res_q = ra_input | rb_input;
            OR_WITH_COMPLEMENT:  res_q = ra_input | ~rb_input;
            XOR:                 res_q = ra_input ^ rb_input;
            NAND:                res_q = ~(ra_input & rb_input);
            NOR:                 res_q = ~(ra_input | rb_input);
            default:             res_q = '0;
        endcase
    end

    // Halfword lanes, j = 0 is the least-significant halfword
    always_comb begin
        logic [15:0] ha, hb, hr;
        res_h = '0;
        ha = '0; hb = '0; hr = '0;
        for (int j = 0; j < 8; j++) begin
            ha = ra_input[16*j +: 16];
            hb = rb_input[16*j +: 16];
            case (ep_input_op_code)
                ADD_HALFWORD:                          hr = ha + hb;
                ADD_HALFWORD_IMMEDIATE:                hr = ha + i10_h;
                SUBTRACT_FROM_HALFWORD:                hr = hb - ha;
                SUBTRACT_FROM_HALFWORD_IMMEDIATE:      hr = i10_h - ha;
                AND_HALFWORD_IMMEDIATE:                hr = ha & i10_h;
                OR_HALFWORD_IMMEDIATE:                 hr = ha | i10_h;
                XOR_HALFWORD_IMMEDIATE:                hr = ha ^ i10_h;
                COMPARE_EQUAL_HALFWORD:                hr = {16{ha == hb}};
                COMPARE_GREATER_THAN_HALFWORD:         hr = {16{$signed(ha) > $signed(hb)}};
                COMPARE_LOGICAL_GREATER_THAN_HALFWORD: hr = {16{ha > hb}};
                IMMEDIATE_LOAD_HALFWORD:               hr = I16_input;
                FORM_SELECT_MASK_HALFWORD:             hr = {16{ra_input[96 + j]}};
                SHIFT_LEFT_HALFWORD:                   hr = shl16(ha, hb[4:0]);
                SHIFT_LEFT_HALFWORD_IMMEDIATE:         hr = shl16(ha, I7_input[4:0]);
                ROTATE_HALFWORD:                       hr = rotl16(ha, hb[3:0]);
                ROTATE_HALFWORD_IMMEDIATE:             hr = rotl16(ha, I7_input[3:0]);
                default:                               hr = '0;
            endcase
            res_h[16*j +: 16] = hr;
        end
    end

    // Word lanes: integer, multiply and float ops
    always_comb begin
        logic [31:0] wa, wb, wc, wr;
        real         pr, cr;
        res_w = '0;
        wa = '0; wb = '0; wc = '0; wr = '0;
        pr = 0.0; cr = 0.0;
        for (int j = 0; j < 4; j++) begin
            wa = ra_input[32*j +: 32];
            wb = rb_input[32*j +: 32];
            wc = rc_input[32*j +: 32];
            pr = sp_to_real(wa) * sp_to_real(wb);
            cr = sp_to_real(wc);
            case (ep_input_op_code)
                ADD_WORD:                          wr = wa + wb;
                ADD_WORD_IMMEDIATE:                wr = wa + i10_w;
                SUBTRACT_FROM_WORD:                wr = wb - wa;
                SUBTRACT_FROM_WORD_IMMEDIATE:      wr = i10_w - wa;
                CARRY_GENERATE:                    wr = 32'(({1'b0, wa} + {1'b0, wb}) >> 32);
                BORROW_GENERATE:                   wr = 32'(wb >= wa);
                AND_WORD_IMMEDIATE:                wr = wa & i10_w;
                OR_WORD_IMMEDIATE:                 wr = wa | i10_w;
                XOR_WORD_IMMEDIATE:                wr = wa ^ i10_w;
                COMPARE_EQUAL_WORD:                wr = {32{wa == wb}};
                COMPARE_GREATER_THAN_WORD:         wr = {32{$signed(wa) > $signed(wb)}};
                COMPARE_LOGICAL_GREATER_THAN_WORD: wr = {32{wa > wb}};
                IMMEDIATE_LOAD_HALFWORD_UPPER:     wr = {I16_input, 16'd0};
                IMMEDIATE_LOAD_WORD:               wr = {{16{I16_input[15]}}, I16_input};
                IMMEDIATE_LOAD_ADDRESS:            wr = 32'(I18_input);
                FORM_SELECT_MASK_WORD:             wr = {32{ra_input[96 + j]}};
                COUNT_LEADING_ZEROS:               wr = clz32(wa);
                SHIFT_LEFT_WORD:                   wr = shl32(wa, wb[5:0]);
                SHIFT_LEFT_WORD_IMMEDIATE:         wr = shl32(wa, I7_input[5:0]);
                ROTATE_WORD:                       wr = rotl32(wa, wb[4:0]);
                ROTATE_WORD_IMMEDIATE:             wr = rotl32(wa, I7_input[4:0]);
                SUM_BYTES_INTO_HALFWORDS:          wr = {byte_sum(wb), byte_sum(wa)};
                FLOATING_MULTIPLY:                 wr = real_to_sp(pr);
                FLOATING_MULTIPLY_AND_ADD:         wr = real_to_sp(pr + cr);
                FLOATING_MULTIPLY_AND_SUBTRACT:    wr = real_to_sp(pr - cr);
                FLOATING_NEGATIVE_MULTIPLY_AND_SUBTRACT: wr = real_to_sp(cr - pr);
                MULTIPLY:                          wr = 32'($signed(wa[15:0])) * 32'($signed(wb[15:0]));
                MULTIPLY_UNSIGNED:                 wr = 32'(wa[15:0]) * 32'(wb[15:0]);
                MULTIPLY_IMMEDIATE:                wr = 32'($signed(wa[15:0])) * i10_w;
                MULTIPLY_UNSIGNED_IMMEDIATE:       wr = 32'(wa[15:0]) * 32'(i10_w[15:0]);
                MULTIPLY_AND_ADD:                  wr = 32'($signed(wa[15:0])) * 32'($signed(wb[15:0])) + wc;
                MULTIPLY_HIGH:                     wr = (32'(wa[31:16]) * 32'(wb[15:0])) << 16;
                default:                           wr = '0;
            endcase
            res_w[32*j +: 32] = wr;
        end
    end

    always_comb begin
        logic [7:0] ba, bb, br;
        res_b = '0;
        ba = '0; bb = '0; br = '0;
        for (int j = 0; j < 16; j++) begin
            ba = ra_input[8*j +: 8];
            bb = rb_input[8*j +: 8];
            case (ep_input_op_code)
                ABSOLUTE_DIFFERENCE_OF_BYTES: br = (ba > bb) ? ba - bb : bb - ba;
                AVERAGE_BYTES:                br = 8'((9'(ba) + 9'(bb) + 9'd1) >> 1);
                COUNT_ONES_IN_BYTES:          br = 8'($countones(ba));
                default:                      br = '0;
            endcase
            res_b[8*j +: 8] = br;
        end
    end

    always_comb begin
        issue_pkt            = '0;
        issue_pkt.result     = res_q | res_h | res_w | res_b;
        issue_pkt.rt_address = (lat != 4'd0) ? rt_address_input : 7'd0;
        issue_pkt.unit_id    = unit;
        issue_pkt.latency    = lat;
    end

    // Write enable rises once the packet has travelled as deep as its latency
    function automatic ep_packet_t at_stage(input ep_packet_t p, input int unsigned k);
        ep_packet_t q;
        q       = p;
        q.wr_en = (p.latency != 4'd0) && (k >= 32'(p.latency));
        return q;
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 1; k <= STAGES; k++) stage[k] <= '0;
        end else begin
            stage[1] <= at_stage(issue_pkt, 1);
            for (int k = 2; k <= STAGES; k++) stage[k] <= at_stage(stage[k-1], 32'(k));
        end
    end

    assign fw_ep_st_1 = stage[1];
    assign fw_ep_st_2 = stage[2];
    assign fw_ep_st_3 = stage[3];
    assign fw_ep_st_4 = stage[4];
    assign fw_ep_st_5 = stage[5];
    assign fw_ep_st_6 = stage[6];
    assign fw_ep_st_7 = stage[7];
    assign out_ep     = stage[7];
endmodule

// File: tb/tb_even_pipe.sv
// Directed bench for even_pipe: hand-computed packets checked per stage,
// including write-enable timing and mid-stream asynchronous reset.
module tb_even_pipe;
    import descriptions::*;

    logic         clock;
    logic         reset;
    opcode        op;
    logic [127:0] ra, rb, rc;
    logic [6:0]   rt, i7;
    logic [9:0]   i10;
    logic [15:0]  i16;
    logic [17:0]  i18;
    logic [142:0] st1, st2, st3, st4, st5, st6, st7, out_ep;
    int           total = 0;
    int           bad   = 0;

    even_pipe dut (
        .clock(clock), .reset(reset), .ep_input_op_code(op),
        .ra_input(ra), .rb_input(rb), .rc_input(rc), .rt_address_input(rt),
        .I7_input(i7), .I10_input(i10), .I16_input(i16), .I18_input(i18),
        .fw_ep_st_1(st1), .fw_ep_st_2(st2), .fw_ep_st_3(st3), .fw_ep_st_4(st4),
        .fw_ep_st_5(st5), .fw_ep_st_6(st6), .fw_ep_st_7(st7), .out_ep(out_ep)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [142:0] got, input logic [142:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [142:0] pkt(input logic [127:0] r, input logic [6:0] a,
                                         input logic we, input logic [2:0] u, input logic [3:0] l);
        return {r, a, we, u, l};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Issue the op currently on the inputs for exactly one cycle
    task automatic go();
        tick(1);
        op = NOP;
    endtask

    initial begin
        reset = 1'b1; op = NOP;
        ra = '0; rb = '0; rc = '0; rt = '0; i7 = '0; i10 = '0; i16 = '0; i18 = '0;
        tick(2);
        check("reset_st1", st1, '0);
        check("reset_out", out_ep, '0);
        reset = 1'b0;

        op = ADD_WORD; ra = 128'd20; rb = 128'd10; rt = 7'd5; go();
        check("add_st1", st1, pkt(128'd30, 7'd5, 1'b0, 3'd1, 4'd2));
        tick(1);
        check("add_st2", st2, pkt(128'd30, 7'd5, 1'b1, 3'd1, 4'd2));
        tick(5);
        check("add_out", out_ep, pkt(128'd30, 7'd5, 1'b1, 3'd1, 4'd2));
        check("add_st1_idle", st1, '0);

        op = SUBTRACT_FROM_HALFWORD_IMMEDIATE; ra = 128'd21; i10 = 10'd36; rt = 7'd9; go();
        check("sfhi", st1, pkt({{7{16'h0024}}, 16'h000F}, 7'd9, 1'b0, 3'd1, 4'd2));

        op = COUNT_LEADING_ZEROS; ra = 128'd1025; rt = 7'd3; go();
        check("clz", st1, pkt({32'd32, 32'd32, 32'd32, 32'd21}, 7'd3, 1'b0, 3'd1, 4'd2));

        op = COUNT_ONES_IN_BYTES; ra = 128'd216; rt = 7'd4; go();
        check("cntb", st1, pkt(128'd4, 7'd4, 1'b0, 3'd3, 4'd4));

        op = CARRY_GENERATE; ra = 128'd25; rb = 128'd45; rt = 7'd6; go();
        check("cg", st1, pkt(128'd0, 7'd6, 1'b0, 3'd1, 4'd2));

        op = COMPARE_EQUAL_HALFWORD; ra = 128'd234; rb = 128'd234; rt = 7'd7; go();
        check("ceqh", st1, pkt({128{1'b1}}, 7'd7, 1'b0, 3'd1, 4'd2));

        op = COMPARE_LOGICAL_GREATER_THAN_WORD; ra = {96'd0, 32'hFFFF_FFFF}; rb = 128'd1; rt = 7'd8; go();
        check("clgt", st1, pkt({96'd0, 32'hFFFF_FFFF}, 7'd8, 1'b0, 3'd1, 4'd2));
        op = COMPARE_GREATER_THAN_WORD; go();
        check("cgt_signed", st1, pkt(128'd0, 7'd8, 1'b0, 3'd1, 4'd2));

        op = IMMEDIATE_LOAD_HALFWORD; i16 = 16'hBEEF; rt = 7'd10; go();
        check("ilh", st1, pkt({8{16'hBEEF}}, 7'd10, 1'b0, 3'd1, 4'd2));

        op = IMMEDIATE_LOAD_ADDRESS; i18 = 18'h3FFFF; rt = 7'd11; go();
        check("ila", st1, pkt({4{32'h0003_FFFF}}, 7'd11, 1'b0, 3'd1, 4'd2));

        op = SHIFT_LEFT_HALFWORD; ra = {8{16'h0001}};
        rb = {16'd0, 16'd1, 16'd15, 16'd16, 16'd17, 16'd31, 16'd4, 16'd8}; rt = 7'd12; go();
        check("shlh", st1, pkt({16'h0001, 16'h0002, 16'h8000, 16'h0, 16'h0, 16'h0, 16'h0010, 16'h0100},
                               7'd12, 1'b0, 3'd2, 4'd4));
        tick(2);
        check("shlh_st3_we", st3, pkt({16'h0001, 16'h0002, 16'h8000, 16'h0, 16'h0, 16'h0, 16'h0010, 16'h0100},
                                      7'd12, 1'b0, 3'd2, 4'd4));
        tick(1);
        check("shlh_st4_we", st4, pkt({16'h0001, 16'h0002, 16'h8000, 16'h0, 16'h0, 16'h0, 16'h0010, 16'h0100},
                                      7'd12, 1'b1, 3'd2, 4'd4));

        op = ROTATE_WORD_IMMEDIATE; ra = {32'h8000_0001, 32'h1234_5678, 32'h0, 32'hF000_000F};
        i7 = 7'd4; rt = 7'd13; go();
        check("roti", st1, pkt({32'h0000_0018, 32'h2345_6781, 32'h0, 32'h0000_00FF}, 7'd13, 1'b0, 3'd2, 4'd4));

        op = AVERAGE_BYTES; ra = 128'hFF; rb = 128'h01; rt = 7'd14; go();
        check("avgb", st1, pkt(128'h80, 7'd14, 1'b0, 3'd3, 4'd4));

        op = MULTIPLY; ra = 128'd64; rb = 128'd128; rt = 7'd15; go();
        check("mpy_st1", st1, pkt(128'd8192, 7'd15, 1'b0, 3'd5, 4'd7));
        tick(5);
        check("mpy_st6", st6, pkt(128'd8192, 7'd15, 1'b0, 3'd5, 4'd7));
        tick(1);
        check("mpy_st7", st7, pkt(128'd8192, 7'd15, 1'b1, 3'd5, 4'd7));

        op = MULTIPLY_AND_ADD; ra = 128'h0000_FFFD; rb = 128'd7; rc = 128'd100; rt = 7'd16; go();
        check("mpya", st1, pkt(128'd79, 7'd16, 1'b0, 3'd5, 4'd7));

        op = FLOATING_MULTIPLY_AND_ADD; ra = {96'd0, 32'h3FC0_0000}; rb = {96'd0, 32'h4000_0000};
        rc = {96'd0, 32'h3F80_0000}; rt = 7'd17; go();
        check("fma", st1, pkt({96'd0, 32'h4080_0000}, 7'd17, 1'b0, 3'd4, 4'd6));
        op = FLOATING_NEGATIVE_MULTIPLY_AND_SUBTRACT; go();
        check("fnms", st1, pkt({96'd0, 32'hC000_0000}, 7'd17, 1'b0, 3'd4, 4'd6));
        tick(4);
        check("fma_st6_we", st6, pkt({96'd0, 32'h4080_0000}, 7'd17, 1'b1, 3'd4, 4'd6));

        op = NOP; ra = 128'd5; rt = 7'd5; go();
        check("nop", st1, '0);
        op = opcode'(7'd127); go();
        check("undef_op", st1, '0);

        for (int i = 1; i <= 7; i++) begin
            op = ADD_WORD; ra = 128'(i); rb = 128'd100; rt = 7'(i);
            tick(1);
        end
        op = NOP;
        check("stream_st1", st1, pkt(128'd107, 7'd7, 1'b0, 3'd1, 4'd2));
        check("stream_st4", st4, pkt(128'd104, 7'd4, 1'b1, 3'd1, 4'd2));
        check("stream_st7", st7, pkt(128'd101, 7'd1, 1'b1, 3'd1, 4'd2));

        #2 reset = 1'b1;
        #1;
        check("midrst_st1", st1, '0);
        check("midrst_st2", st2, '0);
        check("midrst_st3", st3, '0);
        check("midrst_st4", st4, '0);
        check("midrst_st5", st5, '0);
        check("midrst_st6", st6, '0);
        check("midrst_st7", st7, '0);
        check("midrst_out", out_ep, '0);
        tick(1);
        reset = 1'b0;

        op = ADD_WORD; ra = 128'd2; rb = 128'd3; rt = 7'd1; go();
        check("resume_st1", st1, pkt(128'd5, 7'd1, 1'b0, 3'd1, 4'd2));
        tick(6);
        check("resume_out", out_ep, pkt(128'd5, 7'd1, 1'b1, 3'd1, 4'd2));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
